// File: rtl/level_debouncer.sv
// Purpose : turns a raw asynchronous, bouncy level into a clean level that is synchronous to clock.
// Latency : with sample_enable held high, level_out follows a clean step SYNC_DEPTH + STABLE_CYCLES edges after capture.
// Backpres: there is no handshake; sample_enable only gates qualification, and the synchronizer shifts on every clock.
//
// Ports:
//   clock          - single clock; all state changes on its rising edge
//   reset_n        - asynchronous, active-low reset
//   sample_enable  - qualifies counting (for example a slow tick); tie high to sample every cycle
//   level_async_in - raw asynchronous input level
//   level_out      - debounced level (registered)
//   settling_out   - high while a candidate new level is being qualified (registered)
//   glitch_out     - one-cycle pulse when a candidate is abandoned before acceptance (registered)
module level_debouncer #(
    parameter int   SYNC_DEPTH    = 2,
    parameter int   STABLE_CYCLES = 16,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sample_enable,
    input  logic level_async_in,
    output logic level_out,
    output logic settling_out,
    output logic glitch_out
);

    // Reject illegal parameterisations at elaboration time.
    generate
        if (SYNC_DEPTH < 2) begin : g_bad_sync_depth
            $error("level_debouncer: SYNC_DEPTH must be at least 2");
        end
        if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
            $error("level_debouncer: STABLE_CYCLES must be at least 1");
        end
    endgenerate

    // The counter only ever reaches STABLE_CYCLES-1 before it is cleared,
    // so it cannot wrap.
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // CDC synchronizer: shifts every clock, regardless of sample_enable.
    // ------------------------------------------------------------------
    logic [SYNC_DEPTH-1:0] sync_q;
    logic [SYNC_DEPTH-1:0] sync_d;
    logic                  synced;

    assign sync_d = {sync_q[SYNC_DEPTH-2:0], level_async_in};
    assign synced = sync_q[SYNC_DEPTH-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_DEPTH{RESET_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    // ------------------------------------------------------------------
    // Qualification FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             settling_q, settling_d;
    logic             glitch_q, glitch_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            level_q    <= RESET_LEVEL;
            settling_q <= 1'b0;
            glitch_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            settling_q <= settling_d;
            glitch_q   <= glitch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        glitch_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sample_enable && (synced != level_q)) begin
                    if (STABLE_CYCLES == 1) begin
                        // A single qualifying sample is enough: accept at once.
                        level_d = ~level_q;
                    end else begin
                        // The sample that opens qualification counts as the first.
                        state_d = SETTLE;
                        cnt_d   = CNT_ONE;
                    end
                end
            end

            SETTLE: begin
                // Unsampled cycles hold everything; a bounce is only seen when sampled.
                if (sample_enable) begin
                    if (synced != level_q) begin
                        if (cnt_q == CNT_LAST) begin
                            level_d = ~level_q;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_d    = '0;
                        glitch_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Registered alongside the state so it tracks SETTLE exactly.
        settling_d = (state_d == SETTLE);
    end

    assign level_out    = level_q;
    assign settling_out = settling_q;
    assign glitch_out   = glitch_q;

endmodule
